// File: rtl/control_unit.sv
// Hardwired Moore sequencer for the CPU datapath: fetch T0-T3, then per-opcode execute steps T4-T8.
// Optional feature macro: CTRL_MULDIV_EN enables the mul/div execute sequence (otherwise they halt).
module control_unit #(
  parameter int              OP_W    = 5,
  parameter logic [OP_W-1:0] ALU_ADD = 5'b00011
) (
  input  logic            clock,
  input  logic            clear,
  input  logic [OP_W-1:0] ir_op,
  input  logic            con,
  input  logic            stop,
  output logic            PCout,
  output logic            ZLowout,
  output logic            ZHighout,
  output logic            MDRout,
  output logic            HIout,
  output logic            LOout,
  output logic            InPortout,
  output logic            Cout,
  output logic            MAR_enable,
  output logic            MDR_enable,
  output logic            IR_enable,
  output logic            PC_enable,
  output logic            IncPC,
  output logic            Y_enable,
  output logic            Z_low_enable,
  output logic            Z_high_enable,
  output logic            HI_enable,
  output logic            LO_enable,
  output logic            Output_port_enable,
  output logic            CON_in,
  output logic            Read,
  output logic            Write,
  output logic            GRA,
  output logic            GRB,
  output logic            GRC,
  output logic            Rin,
  output logic            Rout,
  output logic            BAout,
  output logic            R15in,
  output logic [OP_W-1:0] operation,
  output logic            run
);

  localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OP_W-1:0] OP_ROR  = 5'b00111;
  localparam logic [OP_W-1:0] OP_ROL  = 5'b01000;
  localparam logic [OP_W-1:0] OP_SHR  = 5'b01001;
  localparam logic [OP_W-1:0] OP_SHRA = 5'b01010;
  localparam logic [OP_W-1:0] OP_SHL  = 5'b01011;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OP_W-1:0] OP_ANDI = 5'b01101;
  localparam logic [OP_W-1:0] OP_ORI  = 5'b01110;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b10000;
  localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;
  localparam logic [OP_W-1:0] OP_BR   = 5'b10011;
  localparam logic [OP_W-1:0] OP_JR   = 5'b10100;
  localparam logic [OP_W-1:0] OP_JAL  = 5'b10101;
  localparam logic [OP_W-1:0] OP_IN   = 5'b10110;
  localparam logic [OP_W-1:0] OP_OUT  = 5'b10111;
  localparam logic [OP_W-1:0] OP_MFHI = 5'b11000;
  localparam logic [OP_W-1:0] OP_MFLO = 5'b11001;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_T8, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_RTYPE, C_IMM, C_LD, C_LDI, C_ST, C_BR, C_JR, C_JAL,
    C_MFHI, C_MFLO, C_IN, C_OUT, C_NOP, C_MULDIV, C_HALT
  } cls_t;

  typedef struct packed {
    logic            pc_out;
    logic            zlow_out;
    logic            zhigh_out;
    logic            mdr_out;
    logic            hi_out;
    logic            lo_out;
    logic            inport_out;
    logic            c_out;
    logic            mar_en;
    logic            mdr_en;
    logic            ir_en;
    logic            pc_en;
    logic            inc_pc;
    logic            y_en;
    logic            zlow_en;
    logic            zhigh_en;
    logic            hi_en;
    logic            lo_en;
    logic            outport_en;
    logic            con_in;
    logic            read;
    logic            write;
    logic            gra;
    logic            grb;
    logic            grc;
    logic            rin;
    logic            rout;
    logic            ba_out;
    logic            r15_in;
    logic [OP_W-1:0] operation;
  } ctrl_t;

  state_t          state, nxt_state;
  logic [OP_W-1:0] op_q, nxt_op;
  ctrl_t           ctrl_q;
  logic            run_q;
  cls_t            cls_cur, cls_new;
  logic [2:0]      step;

  function automatic cls_t op_class(input logic [OP_W-1:0] op);
    cls_t c;
    case (op)
      OP_LD:   c = C_LD;
      OP_LDI:  c = C_LDI;
      OP_ST:   c = C_ST;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL,
      OP_NEG, OP_NOT:
               c = C_RTYPE;
      OP_ADDI, OP_ANDI, OP_ORI:
               c = C_IMM;
`ifdef CTRL_MULDIV_EN
      OP_DIV, OP_MUL: c = C_MULDIV;
`else
      OP_DIV, OP_MUL: c = C_HALT;
`endif
      OP_BR:   c = C_BR;
      OP_JR:   c = C_JR;
      OP_JAL:  c = C_JAL;
      OP_IN:   c = C_IN;
      OP_OUT:  c = C_OUT;
      OP_MFHI: c = C_MFHI;
      OP_MFLO: c = C_MFLO;
      OP_NOP:  c = C_NOP;
      default: c = C_HALT;
    endcase
    return c;
  endfunction

  // Number of execute steps (E1..En) for each instruction class.
  function automatic logic [2:0] n_steps(input cls_t c);
    logic [2:0] n;
    case (c)
      C_RTYPE, C_IMM, C_LDI:              n = 3'd3;
      C_LD, C_ST:                         n = 3'd5;
      C_BR, C_MULDIV:                     n = 3'd4;
      C_JAL:                              n = 3'd2;
      C_JR, C_MFHI, C_MFLO, C_IN, C_OUT:  n = 3'd1;
      default:                            n = 3'd0;
    endcase
    return n;
  endfunction

  function automatic logic [2:0] exec_step(input state_t s);
    logic [2:0] e;
    case (s)
      S_T4:    e = 3'd1;
      S_T5:    e = 3'd2;
      S_T6:    e = 3'd3;
      S_T7:    e = 3'd4;
      S_T8:    e = 3'd5;
      default: e = 3'd0;
    endcase
    return e;
  endfunction

  // Control set for a state/opcode pair; evaluated on the next state so outputs come straight from flops.
  function automatic ctrl_t decode(input state_t s, input logic [OP_W-1:0] op, input logic c);
    ctrl_t o;
    cls_t  k;
    logic [2:0] e;
    o = '0;
    k = op_class(op);
    e = exec_step(s);
    case (s)
      S_T0: begin o.pc_out = 1'b1; o.mar_en = 1'b1; o.inc_pc = 1'b1; end
      S_T1: o.read = 1'b1;
      S_T2: begin o.read = 1'b1; o.mdr_en = 1'b1; end
      S_T3: begin o.mdr_out = 1'b1; o.ir_en = 1'b1; end
      S_T4, S_T5, S_T6, S_T7, S_T8: begin
        case (k)
          C_RTYPE, C_IMM: begin
            case (e)
              3'd1: begin o.grb = 1'b1; o.rout = 1'b1; o.y_en = 1'b1; end
              3'd2: begin
                if (k == C_RTYPE) begin
                  o.grc  = 1'b1;
                  o.rout = 1'b1;
                end else begin
                  o.c_out = 1'b1;
                end
                o.operation = op;
                o.zlow_en   = 1'b1;
              end
              3'd3: begin o.zlow_out = 1'b1; o.gra = 1'b1; o.rin = 1'b1; end
              default: ;
            endcase
          end
          C_LD, C_LDI, C_ST: begin
            case (e)
              3'd1: begin o.grb = 1'b1; o.ba_out = 1'b1; o.y_en = 1'b1; end
              3'd2: begin o.c_out = 1'b1; o.operation = ALU_ADD; o.zlow_en = 1'b1; end
              3'd3: begin
                o.zlow_out = 1'b1;
                if (k == C_LDI) begin
                  o.gra = 1'b1;
                  o.rin = 1'b1;
                end else begin
                  o.mar_en = 1'b1;
                end
              end
              3'd4: begin
                o.mdr_en = 1'b1;
                if (k == C_LD) begin
                  o.read = 1'b1;
                end else begin
                  o.gra  = 1'b1;
                  o.rout = 1'b1;
                end
              end
              3'd5: begin
                if (k == C_LD) begin
                  o.mdr_out = 1'b1;
                  o.gra     = 1'b1;
                  o.rin     = 1'b1;
                end else begin
                  o.write = 1'b1;
                end
              end
              default: ;
            endcase
          end
          C_BR: begin
            case (e)
              3'd1: begin o.gra = 1'b1; o.rout = 1'b1; o.con_in = 1'b1; end
              3'd2: begin o.pc_out = 1'b1; o.y_en = 1'b1; end
              3'd3: begin o.c_out = 1'b1; o.operation = ALU_ADD; o.zlow_en = 1'b1; end
              // Branch is taken only if CON, captured in E1, is set when E4 is entered.
              3'd4: begin o.zlow_out = c; o.pc_en = c; end
              default: ;
            endcase
          end
          C_JR: begin o.gra = 1'b1; o.rout = 1'b1; o.pc_en = 1'b1; end
          C_JAL: begin
            if (e == 3'd1) begin
              o.pc_out = 1'b1;
              o.r15_in = 1'b1;
            end else begin
              o.gra   = 1'b1;
              o.rout  = 1'b1;
              o.pc_en = 1'b1;
            end
          end
          C_MFHI: begin o.hi_out = 1'b1; o.gra = 1'b1; o.rin = 1'b1; end
          C_MFLO: begin o.lo_out = 1'b1; o.gra = 1'b1; o.rin = 1'b1; end
          C_IN:   begin o.inport_out = 1'b1; o.gra = 1'b1; o.rin = 1'b1; end
          C_OUT:  begin o.gra = 1'b1; o.rout = 1'b1; o.outport_en = 1'b1; end
`ifdef CTRL_MULDIV_EN
          C_MULDIV: begin
            case (e)
              3'd1: begin o.gra = 1'b1; o.rout = 1'b1; o.y_en = 1'b1; end
              3'd2: begin
                o.grb       = 1'b1;
                o.rout      = 1'b1;
                o.operation = op;
                o.zlow_en   = 1'b1;
                o.zhigh_en  = 1'b1;
              end
              3'd3: begin o.zlow_out = 1'b1; o.lo_en = 1'b1; end
              3'd4: begin o.zhigh_out = 1'b1; o.hi_en = 1'b1; end
              default: ;
            endcase
          end
`endif
          default: ;
        endcase
      end
      default: ;
    endcase
    return o;
  endfunction

  always_comb begin
    nxt_state = state;
    nxt_op    = op_q;
    cls_cur   = op_class(op_q);
    cls_new   = op_class(ir_op);
    step      = exec_step(state);
    case (state)
      S_RESET: nxt_state = S_T0;
      S_T0:    nxt_state = S_T1;
      S_T1:    nxt_state = S_T2;
      S_T2:    nxt_state = S_T3;
      S_T3: begin
        nxt_op = ir_op;
        if (cls_new == C_HALT)
          nxt_state = S_HALT;
        else if (n_steps(cls_new) == 3'd0)
          nxt_state = stop ? S_HALT : S_T0;
        else
          nxt_state = S_T4;
      end
      S_T4, S_T5, S_T6, S_T7, S_T8: begin
        if (step >= n_steps(cls_cur))
          nxt_state = stop ? S_HALT : S_T0;
        else
          nxt_state = state_t'(state + 4'd1);
      end
      S_HALT:  nxt_state = S_HALT;
      default: nxt_state = S_RESET;
    endcase
  end

  // Stage boundary: state, latched opcode and the full control set all register together.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state  <= S_RESET;
      op_q   <= '0;
      ctrl_q <= '0;
      run_q  <= 1'b0;
    end else begin
      state  <= nxt_state;
      op_q   <= nxt_op;
      ctrl_q <= decode(nxt_state, nxt_op, con);
      run_q  <= (nxt_state != S_RESET) && (nxt_state != S_HALT);
    end
  end

  assign PCout              = ctrl_q.pc_out;
  assign ZLowout            = ctrl_q.zlow_out;
  assign ZHighout           = ctrl_q.zhigh_out;
  assign MDRout             = ctrl_q.mdr_out;
  assign HIout              = ctrl_q.hi_out;
  assign LOout              = ctrl_q.lo_out;
  assign InPortout          = ctrl_q.inport_out;
  assign Cout               = ctrl_q.c_out;
  assign MAR_enable         = ctrl_q.mar_en;
  assign MDR_enable         = ctrl_q.mdr_en;
  assign IR_enable          = ctrl_q.ir_en;
  assign PC_enable          = ctrl_q.pc_en;
  assign IncPC              = ctrl_q.inc_pc;
  assign Y_enable           = ctrl_q.y_en;
  assign Z_low_enable       = ctrl_q.zlow_en;
  assign Z_high_enable      = ctrl_q.zhigh_en;
  assign HI_enable          = ctrl_q.hi_en;
  assign LO_enable          = ctrl_q.lo_en;
  assign Output_port_enable = ctrl_q.outport_en;
  assign CON_in             = ctrl_q.con_in;
  assign Read               = ctrl_q.read;
  assign Write              = ctrl_q.write;
  assign GRA                = ctrl_q.gra;
  assign GRB                = ctrl_q.grb;
  assign GRC                = ctrl_q.grc;
  assign Rin                = ctrl_q.rin;
  assign Rout               = ctrl_q.rout;
  assign BAout              = ctrl_q.ba_out;
  assign R15in              = ctrl_q.r15_in;
  assign operation          = ctrl_q.operation;
  assign run                = run_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed instruction steps plus random opcode streams checked
// cycle by cycle against a per-instruction step-list model.
module tb_control_unit;

  logic       clock = 1'b0;
  logic       clear = 1'b0;
  logic [4:0] ir_op = 5'd0;
  logic       con   = 1'b0;
  logic       stop  = 1'b0;
  logic PCout, ZLowout, ZHighout, MDRout, HIout, LOout, InPortout, Cout;
  logic MAR_enable, MDR_enable, IR_enable, PC_enable, IncPC, Y_enable;
  logic Z_low_enable, Z_high_enable, HI_enable, LO_enable, Output_port_enable, CON_in;
  logic Read, Write, GRA, GRB, GRC, Rin, Rout, BAout, R15in, run;
  logic [4:0] operation;

  int checks   = 0;
  int failures = 0;

  control_unit dut (
    .clock(clock), .clear(clear), .ir_op(ir_op), .con(con), .stop(stop),
    .PCout(PCout), .ZLowout(ZLowout), .ZHighout(ZHighout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .Cout(Cout),
    .MAR_enable(MAR_enable), .MDR_enable(MDR_enable), .IR_enable(IR_enable),
    .PC_enable(PC_enable), .IncPC(IncPC), .Y_enable(Y_enable),
    .Z_low_enable(Z_low_enable), .Z_high_enable(Z_high_enable),
    .HI_enable(HI_enable), .LO_enable(LO_enable),
    .Output_port_enable(Output_port_enable), .CON_in(CON_in),
    .Read(Read), .Write(Write), .GRA(GRA), .GRB(GRB), .GRC(GRC),
    .Rin(Rin), .Rout(Rout), .BAout(BAout), .R15in(R15in),
    .operation(operation), .run(run)
  );

  always #5 clock = ~clock;

  // Bit positions of each control in the packed observation word.
  localparam int PCO = 0,  ZLO = 1,  ZHO = 2,  MDRO = 3, HIO = 4,  LOO = 5,  INO = 6,  CO = 7;
  localparam int MARE = 8, MDRE = 9, IRE = 10, PCE = 11, INCPC = 12, YE = 13, ZLE = 14, ZHE = 15;
  localparam int HIE = 16, LOE = 17, OPE = 18, CONI = 19, RD = 20, WR = 21;
  localparam int GA = 22, GB = 23, GC = 24, RIN = 25, ROUT = 26, BAO = 27, R15 = 28;
  localparam logic [34:0] RUNB = 35'd1 << 34;
  localparam logic [34:0] ZERO = 35'd0;

  logic [34:0] exp_q[$];

  function automatic logic [34:0] sample_outs();
    return {run, operation, R15in, BAout, Rout, Rin, GRC, GRB, GRA, Write, Read, CON_in,
            Output_port_enable, LO_enable, HI_enable, Z_high_enable, Z_low_enable, Y_enable,
            IncPC, PC_enable, IR_enable, MDR_enable, MAR_enable, Cout, InPortout, LOout,
            HIout, MDRout, ZHighout, ZLowout, PCout};
  endfunction

  function automatic logic [34:0] b(input int i);
    return 35'd1 << i;
  endfunction

  function automatic logic [34:0] opv(input logic [4:0] o);
    return {1'b0, o, 29'd0};
  endfunction

  task automatic chk(input string tag, input logic [34:0] got, input logic [34:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  // Expected control set for every cycle of one instruction, fetch included.
  task automatic build(input logic [4:0] op, input logic c, output bit halts_op);
    exp_q.delete();
    halts_op = 1'b0;
    exp_q.push_back(RUNB | b(PCO) | b(MARE) | b(INCPC));
    exp_q.push_back(RUNB | b(RD));
    exp_q.push_back(RUNB | b(RD) | b(MDRE));
    exp_q.push_back(RUNB | b(MDRO) | b(IRE));
    if (op inside {[5'd3:5'd11], 5'd17, 5'd18}) begin
      exp_q.push_back(RUNB | b(GB) | b(ROUT) | b(YE));
      exp_q.push_back(RUNB | b(GC) | b(ROUT) | opv(op) | b(ZLE));
      exp_q.push_back(RUNB | b(ZLO) | b(GA) | b(RIN));
    end else if (op inside {[5'd12:5'd14]}) begin
      exp_q.push_back(RUNB | b(GB) | b(ROUT) | b(YE));
      exp_q.push_back(RUNB | b(CO) | opv(op) | b(ZLE));
      exp_q.push_back(RUNB | b(ZLO) | b(GA) | b(RIN));
    end else if (op inside {5'd0, 5'd1, 5'd2}) begin
      exp_q.push_back(RUNB | b(GB) | b(BAO) | b(YE));
      exp_q.push_back(RUNB | b(CO) | opv(5'b00011) | b(ZLE));
      if (op == 5'd1) begin
        exp_q.push_back(RUNB | b(ZLO) | b(GA) | b(RIN));
      end else begin
        exp_q.push_back(RUNB | b(ZLO) | b(MARE));
        if (op == 5'd0) begin
          exp_q.push_back(RUNB | b(RD) | b(MDRE));
          exp_q.push_back(RUNB | b(MDRO) | b(GA) | b(RIN));
        end else begin
          exp_q.push_back(RUNB | b(GA) | b(ROUT) | b(MDRE));
          exp_q.push_back(RUNB | b(WR));
        end
      end
    end else if (op == 5'd19) begin
      exp_q.push_back(RUNB | b(GA) | b(ROUT) | b(CONI));
      exp_q.push_back(RUNB | b(PCO) | b(YE));
      exp_q.push_back(RUNB | b(CO) | opv(5'b00011) | b(ZLE));
      exp_q.push_back(c ? (RUNB | b(ZLO) | b(PCE)) : RUNB);
    end else if (op == 5'd20) begin
      exp_q.push_back(RUNB | b(GA) | b(ROUT) | b(PCE));
    end else if (op == 5'd21) begin
      exp_q.push_back(RUNB | b(PCO) | b(R15));
      exp_q.push_back(RUNB | b(GA) | b(ROUT) | b(PCE));
    end else if (op == 5'd22) begin
      exp_q.push_back(RUNB | b(INO) | b(GA) | b(RIN));
    end else if (op == 5'd23) begin
      exp_q.push_back(RUNB | b(GA) | b(ROUT) | b(OPE));
    end else if (op == 5'd24) begin
      exp_q.push_back(RUNB | b(HIO) | b(GA) | b(RIN));
    end else if (op == 5'd25) begin
      exp_q.push_back(RUNB | b(LOO) | b(GA) | b(RIN));
    end else if (op == 5'd26) begin
      // nop: fetch only
    end else if (op == 5'd15 || op == 5'd16) begin
`ifdef CTRL_MULDIV_EN
      exp_q.push_back(RUNB | b(GA) | b(ROUT) | b(YE));
      exp_q.push_back(RUNB | b(GB) | b(ROUT) | opv(op) | b(ZLE) | b(ZHE));
      exp_q.push_back(RUNB | b(ZLO) | b(LOE));
      exp_q.push_back(RUNB | b(ZHO) | b(HIE));
`else
      halts_op = 1'b1;
`endif
    end else begin
      halts_op = 1'b1;
    end
  endtask

  // Entered #1 after the edge into T0; leaves #1 after the edge following the instruction.
  task automatic run_instr(input string tag, input logic [4:0] op, input logic c,
                           input logic stp, output bit halted);
    bit h;
    ir_op = op;
    con   = c;
    stop  = stp;
    build(op, c, h);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) begin
        @(posedge clock);
        #1;
      end
      chk($sformatf("%s.cyc%0d", tag, i), sample_outs(), exp_q[i]);
    end
    @(posedge clock);
    #1;
    halted = h || stp;
    if (halted) chk($sformatf("%s.halt", tag), sample_outs(), ZERO);
  endtask

  task automatic do_reset();
    clear = 1'b0;
    stop  = 1'b0;
    con   = 1'b0;
    ir_op = 5'd0;
    repeat (3) begin
      @(posedge clock);
      #1;
      chk("reset_zero", sample_outs(), ZERO);
    end
    #3 clear = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    bit hl;
    logic [4:0] rop;
    int r;

    do_reset();
    run_instr("add",  5'b00011, 1'b0, 1'b0, hl);
    run_instr("ld",   5'b00000, 1'b0, 1'b0, hl);
    run_instr("st",   5'b00010, 1'b0, 1'b0, hl);
    run_instr("br0",  5'b10011, 1'b0, 1'b0, hl);
    run_instr("br1",  5'b10011, 1'b1, 1'b0, hl);
    run_instr("ldi",  5'b00001, 1'b0, 1'b0, hl);
    run_instr("addi", 5'b01100, 1'b0, 1'b0, hl);
    run_instr("jal",  5'b10101, 1'b0, 1'b0, hl);
    run_instr("nop",  5'b11010, 1'b0, 1'b0, hl);
    run_instr("not",  5'b10010, 1'b0, 1'b0, hl);
    run_instr("mul",  5'b10000, 1'b0, 1'b0, hl);
    if (hl) do_reset();

    // stop raised during an instruction lets it finish, then halts
    run_instr("out_stop", 5'b10111, 1'b0, 1'b1, hl);
    repeat (2) begin
      @(posedge clock);
      #1;
      chk("stop_hold", sample_outs(), ZERO);
    end
    do_reset();

    // clear mid-instruction abandons it asynchronously
    ir_op = 5'b00000;
    chk("mid_t0", sample_outs(), RUNB | b(PCO) | b(MARE) | b(INCPC));
    repeat (5) @(posedge clock);
    #2 clear = 1'b0;
    #1 chk("mid_clear", sample_outs(), ZERO);
    do_reset();

    run_instr("halt", 5'b11011, 1'b0, 1'b0, hl);
    repeat (4) begin
      @(posedge clock);
      #1;
      chk("halt_hold", sample_outs(), ZERO);
    end
    do_reset();
    run_instr("illegal", 5'b11111, 1'b0, 1'b0, hl);
    ir_op = 5'b00011;
    repeat (4) begin
      @(posedge clock);
      #1;
      chk("illegal_hold", sample_outs(), ZERO);
    end
    do_reset();

    for (int n = 0; n < 200; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3)      rop = 5'b11011;
      else if (r < 5) rop = 5'($urandom_range(28, 31));
      else            rop = 5'($urandom_range(0, 26));
      run_instr($sformatf("rnd%0d_op%0d", n, rop), rop, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 19) == 0), hl);
      if (hl) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
